// File: rtl/axi_ddr_pkg.sv
// Shared types and constants for the two-master DDR AXI4 arbiter.
package axi_ddr_pkg;

  localparam int DEF_ID_W   = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 64;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {WIDLE, WADDR, WDATA, WRESP} wr_state_t;
  typedef enum logic [1:0] {RIDLE, RADDR, RDATA} rd_state_t;

endpackage

// File: rtl/axi_ddr_arbiter_rr_arb2.sv
// Two-input round-robin picker: a lone requester always wins, a tie goes to
// the port named by ptr.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       enable,
  output logic [1:0] grant
);

  assign grant[0] = enable && req[0] && (!req[1] || !ptr);
  assign grant[1] = enable && req[1] && (!req[0] ||  ptr);

endmodule

// File: rtl/axi_ddr_arbiter.sv
// Shares one AXI4 port between two masters; read and write paths each hold a
// round-robin grant for a whole burst and issue nothing before calibration.
module axi_ddr_arbiter
  import axi_ddr_pkg::*;
#(
  parameter int ID_W   = DEF_ID_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                init_done,
  input  logic                s0_aw_valid,
  output logic                s0_aw_ready,
  input  logic [ID_W-1:0]     s0_aw_id,
  input  logic [ADDR_W-1:0]   s0_aw_addr,
  input  logic [7:0]          s0_aw_len,
  input  logic [2:0]          s0_aw_size,
  input  logic [1:0]          s0_aw_burst,
  input  logic                s0_w_valid,
  output logic                s0_w_ready,
  input  logic [DATA_W-1:0]   s0_w_data,
  input  logic [DATA_W/8-1:0] s0_w_strb,
  input  logic                s0_w_last,
  output logic                s0_b_valid,
  input  logic                s0_b_ready,
  output logic [ID_W-1:0]     s0_b_id,
  output logic [1:0]          s0_b_resp,
  input  logic                s0_ar_valid,
  output logic                s0_ar_ready,
  input  logic [ID_W-1:0]     s0_ar_id,
  input  logic [ADDR_W-1:0]   s0_ar_addr,
  input  logic [7:0]          s0_ar_len,
  input  logic [2:0]          s0_ar_size,
  input  logic [1:0]          s0_ar_burst,
  output logic                s0_r_valid,
  input  logic                s0_r_ready,
  output logic [ID_W-1:0]     s0_r_id,
  output logic [DATA_W-1:0]   s0_r_data,
  output logic [1:0]          s0_r_resp,
  output logic                s0_r_last,
  input  logic                s1_aw_valid,
  output logic                s1_aw_ready,
  input  logic [ID_W-1:0]     s1_aw_id,
  input  logic [ADDR_W-1:0]   s1_aw_addr,
  input  logic [7:0]          s1_aw_len,
  input  logic [2:0]          s1_aw_size,
  input  logic [1:0]          s1_aw_burst,
  input  logic                s1_w_valid,
  output logic                s1_w_ready,
  input  logic [DATA_W-1:0]   s1_w_data,
  input  logic [DATA_W/8-1:0] s1_w_strb,
  input  logic                s1_w_last,
  output logic                s1_b_valid,
  input  logic                s1_b_ready,
  output logic [ID_W-1:0]     s1_b_id,
  output logic [1:0]          s1_b_resp,
  input  logic                s1_ar_valid,
  output logic                s1_ar_ready,
  input  logic [ID_W-1:0]     s1_ar_id,
  input  logic [ADDR_W-1:0]   s1_ar_addr,
  input  logic [7:0]          s1_ar_len,
  input  logic [2:0]          s1_ar_size,
  input  logic [1:0]          s1_ar_burst,
  output logic                s1_r_valid,
  input  logic                s1_r_ready,
  output logic [ID_W-1:0]     s1_r_id,
  output logic [DATA_W-1:0]   s1_r_data,
  output logic [1:0]          s1_r_resp,
  output logic                s1_r_last,
  output logic                m_aw_valid,
  input  logic                m_aw_ready,
  output logic [ID_W-1:0]     m_aw_id,
  output logic [ADDR_W-1:0]   m_aw_addr,
  output logic [7:0]          m_aw_len,
  output logic [2:0]          m_aw_size,
  output logic [1:0]          m_aw_burst,
  output logic                m_w_valid,
  input  logic                m_w_ready,
  output logic [DATA_W-1:0]   m_w_data,
  output logic [DATA_W/8-1:0] m_w_strb,
  output logic                m_w_last,
  input  logic                m_b_valid,
  output logic                m_b_ready,
  input  logic [ID_W-1:0]     m_b_id,
  input  logic [1:0]          m_b_resp,
  output logic                m_ar_valid,
  input  logic                m_ar_ready,
  output logic [ID_W-1:0]     m_ar_id,
  output logic [ADDR_W-1:0]   m_ar_addr,
  output logic [7:0]          m_ar_len,
  output logic [2:0]          m_ar_size,
  output logic [1:0]          m_ar_burst,
  input  logic                m_r_valid,
  output logic                m_r_ready,
  input  logic [ID_W-1:0]     m_r_id,
  input  logic [DATA_W-1:0]   m_r_data,
  input  logic [1:0]          m_r_resp,
  input  logic                m_r_last,
  output logic                wr_owner,
  output logic                rd_owner
);

  wr_state_t  r_wrState;
  rd_state_t  r_rdState;
  logic       r_wrOwner, r_wrPtr, r_rdOwner, r_rdPtr;
  logic [1:0] w_wrGrant, w_rdGrant;
  logic       w_wrEnable, w_rdEnable;

  assign w_wrEnable = init_done && (r_wrState == WIDLE);
  assign w_rdEnable = init_done && (r_rdState == RIDLE);

  rr_arb2 u_wrArb (.req({s1_aw_valid, s0_aw_valid}), .ptr(r_wrPtr), .enable(w_wrEnable), .grant(w_wrGrant));
  rr_arb2 u_rdArb (.req({s1_ar_valid, s0_ar_valid}), .ptr(r_rdPtr), .enable(w_rdEnable), .grant(w_rdGrant));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wrState <= WIDLE;
      r_wrOwner <= 1'b0;
      r_wrPtr   <= 1'b0;
    end else begin
      case (r_wrState)
        WIDLE: if (|w_wrGrant) begin
          r_wrOwner <= w_wrGrant[1];
          r_wrState <= WADDR;
        end
        WADDR: if (m_aw_valid && m_aw_ready) r_wrState <= WDATA;
        WDATA: if (m_w_valid && m_w_ready && m_w_last) r_wrState <= WRESP;
        WRESP: if (m_b_valid && m_b_ready) begin
          r_wrPtr   <= ~r_wrOwner;
          r_wrState <= WIDLE;
        end
        default: r_wrState <= WIDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rdState <= RIDLE;
      r_rdOwner <= 1'b0;
      r_rdPtr   <= 1'b0;
    end else begin
      case (r_rdState)
        RIDLE: if (|w_rdGrant) begin
          r_rdOwner <= w_rdGrant[1];
          r_rdState <= RADDR;
        end
        RADDR: if (m_ar_valid && m_ar_ready) r_rdState <= RDATA;
        RDATA: if (m_r_valid && m_r_ready && m_r_last) begin
          r_rdPtr   <= ~r_rdOwner;
          r_rdState <= RIDLE;
        end
        default: r_rdState <= RIDLE;
      endcase
    end
  end

  assign wr_owner = r_wrOwner;
  assign rd_owner = r_rdOwner;

  // Payloads follow the owner register; only valid/ready are gated by state.
  assign m_aw_id    = r_wrOwner ? s1_aw_id    : s0_aw_id;
  assign m_aw_addr  = r_wrOwner ? s1_aw_addr  : s0_aw_addr;
  assign m_aw_len   = r_wrOwner ? s1_aw_len   : s0_aw_len;
  assign m_aw_size  = r_wrOwner ? s1_aw_size  : s0_aw_size;
  assign m_aw_burst = r_wrOwner ? s1_aw_burst : s0_aw_burst;
  assign m_w_data   = r_wrOwner ? s1_w_data   : s0_w_data;
  assign m_w_strb   = r_wrOwner ? s1_w_strb   : s0_w_strb;
  assign m_w_last   = r_wrOwner ? s1_w_last   : s0_w_last;
  assign m_ar_id    = r_rdOwner ? s1_ar_id    : s0_ar_id;
  assign m_ar_addr  = r_rdOwner ? s1_ar_addr  : s0_ar_addr;
  assign m_ar_len   = r_rdOwner ? s1_ar_len   : s0_ar_len;
  assign m_ar_size  = r_rdOwner ? s1_ar_size  : s0_ar_size;
  assign m_ar_burst = r_rdOwner ? s1_ar_burst : s0_ar_burst;

  assign s0_b_id   = m_b_id;
  assign s0_b_resp = m_b_resp;
  assign s1_b_id   = m_b_id;
  assign s1_b_resp = m_b_resp;
  assign s0_r_id   = m_r_id;
  assign s0_r_data = m_r_data;
  assign s0_r_resp = m_r_resp;
  assign s0_r_last = m_r_last;
  assign s1_r_id   = m_r_id;
  assign s1_r_data = m_r_data;
  assign s1_r_resp = m_r_resp;
  assign s1_r_last = m_r_last;

  always_comb begin
    m_aw_valid  = 1'b0;
    m_w_valid   = 1'b0;
    m_b_ready   = 1'b0;
    s0_aw_ready = 1'b0;
    s1_aw_ready = 1'b0;
    s0_w_ready  = 1'b0;
    s1_w_ready  = 1'b0;
    s0_b_valid  = 1'b0;
    s1_b_valid  = 1'b0;
    case (r_wrState)
      WADDR: begin
        m_aw_valid  = r_wrOwner ? s1_aw_valid : s0_aw_valid;
        s0_aw_ready = !r_wrOwner && m_aw_ready;
        s1_aw_ready =  r_wrOwner && m_aw_ready;
      end
      WDATA: begin
        m_w_valid  = r_wrOwner ? s1_w_valid : s0_w_valid;
        s0_w_ready = !r_wrOwner && m_w_ready;
        s1_w_ready =  r_wrOwner && m_w_ready;
      end
      WRESP: begin
        m_b_ready  = r_wrOwner ? s1_b_ready : s0_b_ready;
        s0_b_valid = !r_wrOwner && m_b_valid;
        s1_b_valid =  r_wrOwner && m_b_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    m_ar_valid  = 1'b0;
    m_r_ready   = 1'b0;
    s0_ar_ready = 1'b0;
    s1_ar_ready = 1'b0;
    s0_r_valid  = 1'b0;
    s1_r_valid  = 1'b0;
    case (r_rdState)
      RADDR: begin
        m_ar_valid  = r_rdOwner ? s1_ar_valid : s0_ar_valid;
        s0_ar_ready = !r_rdOwner && m_ar_ready;
        s1_ar_ready =  r_rdOwner && m_ar_ready;
      end
      RDATA: begin
        m_r_ready  = r_rdOwner ? s1_r_ready : s0_r_ready;
        s0_r_valid = !r_rdOwner && m_r_valid;
        s1_r_valid =  r_rdOwner && m_r_valid;
      end
      default: ;
    endcase
  end

endmodule
